sra_behavior: RTL and testbench

- Sequential signed arithmetic right shifter (SRA).
- Shifts an 8-bit two's-complement operand right by a requested amount, one bit per clock, replicating the sign bit into the vacated MSBs.
- Started by a single-cycle `Start` pulse, which loads the operands. Signals completion with a one-cycle `Done` pulse and holds `Result` until the next completion.
- Serves as the shift execution unit in the arithmetic datapath.

---
 rtl/sra_behavior.sv | 121 ++++++++++++
 tb/tb_sra_behavior.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sra_behavior.sv
// -----------------------------------------------------------------------------
// sra_behavior
//
// Sequential signed arithmetic right shifter. A Start pulse seen while idle
// captures the operand and the shift amount. The operand is then shifted right
// one bit per clock, and the sign bit is copied into each vacated MSB. When the
// shift is finished, Result is updated and Done pulses for one cycle. Result
// keeps its value between completions.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   Start   in   start request, sampled only while idle
//   Input1  in   [WIDTH] signed operand (two's complement)
//   Input2  in   [WIDTH] unsigned shift amount, saturated at WIDTH-1
//   Result  out  [WIDTH] registered shifted value, held between operations
//   Busy    out  high while an operation is in progress
//   Done    out  one-cycle pulse in the cycle Result is updated
// -----------------------------------------------------------------------------
module sra_behavior #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Input1,
    input  logic [WIDTH-1:0] Input2,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Done
);

    // The counter only has to hold the saturated amount, which is WIDTH-1.
    localparam int          CW        = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned MAX_SHIFT = WIDTH - 1;

    localparam logic [WIDTH-1:0] MAX_SHIFT_W = WIDTH'(MAX_SHIFT);
    localparam logic [CW-1:0]    MAX_SHIFT_C = CW'(MAX_SHIFT);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]       state_reg,  state_next;
    logic [WIDTH-1:0] work_reg,   work_next;
    logic [CW-1:0]    count_reg,  count_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             done_reg,   done_next;

    logic [CW-1:0]    count_load;
    logic [WIDTH-1:0] work_shr;

    // Any amount of WIDTH-1 or more gives a word made only of sign bits, so
    // larger requests are clamped to WIDTH-1 shifts.
    assign count_load = (Input2 >= MAX_SHIFT_W) ? MAX_SHIFT_C : Input2[CW-1:0];

    // One-bit arithmetic shift: the MSB keeps the sign and every other bit
    // takes the value of its left neighbour.
    assign work_shr[WIDTH-1] = work_reg[WIDTH-1];
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shr
            assign work_shr[gi] = work_reg[gi+1];
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        work_next   = work_reg;
        count_next  = count_reg;
        result_next = result_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    work_next  = Input1;
                    count_next = count_load;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (count_reg != '0) begin
                    work_next  = work_shr;
                    count_next = count_reg - CW'(1);
                end else begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                result_next = work_reg;
                done_next   = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            work_reg   <= '0;
            count_reg  <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            work_reg   <= work_next;
            count_reg  <= count_next;
            result_reg <= result_next;
            done_reg   <= done_next;
        end
    end

    // Busy comes straight from the state. It rises at the start edge, and it
    // drops at the same edge where FINISH returns to IDLE and Done is raised.
    assign Busy   = (state_reg == SHIFT) || (state_reg == FINISH);
    assign Result = result_reg;
    assign Done   = done_reg;

endmodule

// File: tb/tb_sra_behavior.sv
// -----------------------------------------------------------------------------
// tb_sra_behavior
//
// Directed self-checking bench for sra_behavior. Each operation has an operand,
// a shift amount, an expected result and an expected latency, all worked out by
// hand. Latency is the number of rising edges from the start edge to the edge
// where Done rises.
// -----------------------------------------------------------------------------
module tb_sra_behavior;

    logic       clk;
    logic       rst_n;
    logic       Start;
    logic [7:0] Input1;
    logic [7:0] Input2;
    logic [7:0] Result;
    logic       Busy;
    logic       Done;

    int checks = 0;
    int errors = 0;

    sra_behavior #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Start  (Start),
        .Input1 (Input1),
        .Input2 (Input2),
        .Result (Result),
        .Busy   (Busy),
        .Done   (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present the operands with Start high and let one rising edge (edge S)
    // pass. The task returns #1 after edge S with Start low again.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        Input1 = a;
        Input2 = b;
        Start  = 1'b1;
        @(posedge clk);
        #1;
        Start  = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp, input int lat, input logic [7:0] prev);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        start_op(a, b);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
        check({tag, "_hold"}, {24'd0, Result}, {24'd0, prev});
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (Done) begin
                seen = 1'b1;
                n    = k;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_latency"}, n, lat);
        check({tag, "_result"}, {24'd0, Result}, {24'd0, exp});
        check({tag, "_busy_off"}, {31'd0, Busy}, 32'd0);
        $display("op in1=0x%02h in2=%0d result=0x%02h latency=%0d", a, b, Result, n);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
        check({tag, "_result_keep"}, {24'd0, Result}, {24'd0, exp});
    endtask

    // Directed vectors: operand, shift amount, expected result, latency (N+2).
    logic [7:0] vec_a   [7] = '{8'h03, 8'h80, 8'hB5, 8'h80, 8'h7F, 8'h80, 8'h7F};
    logic [7:0] vec_b   [7] = '{8'd4,  8'd3,  8'd2,  8'd200, 8'd255, 8'd7, 8'd6};
    logic [7:0] vec_exp [7] = '{8'h00, 8'hF0, 8'hED, 8'hFF, 8'h00, 8'hFF, 8'h01};
    int         vec_lat [7] = '{6, 5, 4, 9, 9, 9, 8};

    initial begin
        logic [7:0] prev;
        int         dones;
        int         first_lat;

        rst_n  = 1'b0;
        Start  = 1'b0;
        Input1 = 8'h00;
        Input2 = 8'h00;
        #23;
        check("reset_result", {24'd0, Result}, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_done", {31'd0, Done}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic shifts, sign extension and saturation of the shift amount.
        prev = 8'h00;
        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vec_a[i], vec_b[i], vec_exp[i], vec_lat[i], prev);
            prev = vec_exp[i];
        end

        // Zero shift amount, with a second Start and new operands while busy.
        start_op(8'h7F, 8'd0);
        check("zero_busy", {31'd0, Busy}, 32'd1);
        Start     = 1'b1;
        Input1    = 8'h80;
        Input2    = 8'd1;
        dones     = 0;
        first_lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            Start = 1'b0;
            if (Done) begin
                dones++;
                if (first_lat == 0) first_lat = k;
            end
        end
        check("zero_latency", first_lat, 2);
        check("zero_result", {24'd0, Result}, 32'h7F);
        check("busy_start_ignored_dones", dones, 1);
        $display("op in1=0x7f in2=0 result=0x%02h latency=%0d dones=%0d", Result, first_lat, dones);

        // Reset asserted in the middle of an operation, between two edges.
        start_op(8'hC0, 8'd5);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_result", {24'd0, Result}, 32'd0);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_done", {31'd0, Done}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (Done) dones++;
        end
        check("abort_no_done", dones, 0);
        $display("op in1=0xc0 in2=5 aborted by reset result=0x%02h", Result);
        run_op("after_reset", 8'hC0, 8'd5, 8'hFE, 7, 8'h00);

        // Start held high for 20 edges: a new op every 4 cycles, Done at 3,7,...
        Input1 = 8'h40;
        Input2 = 8'd1;
        Start  = 1'b1;
        @(posedge clk);
        #1;
        dones = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 20) Start = 1'b0;
            @(posedge clk);
            #1;
            if (Done) begin
                dones++;
                check($sformatf("held_phase_%0d", k), k % 4, 3);
                check($sformatf("held_result_%0d", k), {24'd0, Result}, 32'h20);
                $display("op in1=0x40 in2=1 result=0x%02h edge=%0d", Result, k);
            end
        end
        check("held_done_count", dones, 5);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
        end
        check("held_idle_busy", {31'd0, Busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
